data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the core's data-memory interface: accepts the core's `ram_addr`/`ram_r`/`ram_w`/`ram_out` requests and returns `ram_in`. It holds a word-organised data RAM with byte-lane writes and a small MMIO window. The window contains a buffered console transmit port with a valid/ready handshake and a free-running cycle counter. It sits beside the core in the top-level harness and is the counterpart of the core's memory controller.

## Interface

Parameters:
- `ADDR_WIDTH`, 10: word-address bits of the RAM (1024 words).
- `FIFO_DEPTH`, 4: console FIFO entries; must be a power of two, ≥2.
- `MMIO_BASE`, 32'hFFFF_0000: base byte address of the MMIO window (64 KiB window; `ram_addr[31:16]` compared).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `ram_r`, input, 1: read strobe from the core.
- `ram_w`, input, 4: byte-lane write enables; lane i covers bits [8i+7:8i].
- `ram_addr`, input, 32: byte address, word-aligned by the core.
- `ram_out`, input, 32: write data from the core (lane-positioned).
- `ram_in`, output, 32: read data to the core, full word.
- `con_data`, output, 8: console byte at FIFO head.
- `con_valid`, output, 1: FIFO non-empty.
- `con_ready`, input, 1: sink accepts the head byte this cycle.
- `con_overflow`, output, 1: sticky flag, set when a push was dropped.

## Operation

- Decode: MMIO when `ram_addr[31:16] == MMIO_BASE[31:16]`; otherwise RAM. RAM index is `ram_addr[ADDR_WIDTH+1:2]`. Upper bits are ignored, so RAM aliases.
- RAM read: combinational. `ram_in` is the indexed word when `ram_r` is 1, else 0.
- RAM write: at the edge, each lane with `ram_w[i]` set stores `ram_out` byte i. Other lanes are unchanged. RAM contents are not reset.
- MMIO offsets (`ram_addr[15:0]`):
  - 0x0 TXDATA. A write with `ram_w[0]` set pushes `ram_out[7:0]`. Reads return 0.
  - 0x4 STATUS. Read returns {29'b0, overflow, empty, full}. Any write with nonzero `ram_w` clears overflow.
  - 0x8 CYCLE_LO: counter bits [31:0], read-only.
  - 0xC CYCLE_HI: counter bits [63:32], read-only.
  - Any other offset reads 0; writes to it are ignored.
- Console FIFO: circular buffer with read/write pointers and a count of width log2(`FIFO_DEPTH`)+1.
  - Pop occurs when `con_valid && con_ready`.
  - `con_data` is the head byte when non-empty, else 8'h00.
- Push/pop boundary rules:
  - Push while full with no pop: byte dropped, overflow set, FIFO unchanged.
  - Push while full with a pop in the same cycle: both occur, and count stays `FIFO_DEPTH`.
  - Push while empty with `con_ready` high: the byte is not bypassed. It appears on `con_valid` next cycle.
  - Overflow clear and a dropped push in the same cycle: set wins.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Cycle counter: 64-bit, +1 every cycle after reset release. It wraps from all-ones to 0.

## Timing

- Read latency 0 cycles (combinational), as required by the single-cycle core.
- Read-during-write to the same word returns the pre-edge value. The written value is visible the next cycle.
- STATUS and CYCLE reads reflect pre-edge state. The value read in cycle N of a counter released at cycle 0 is N.
- FIFO pushes become visible on `con_valid`/`con_data` one cycle after the write edge.
- Reset values:
  - `ram_in` 0 while `rst_n` is low, regardless of `ram_r`.
  - `con_valid` 0, `con_data` 0, `con_overflow` 0.
  - FIFO empty, pointers 0, counter 0.
- Reset mid-operation: queued bytes are discarded immediately, and `con_valid` drops asynchronously. RAM keeps its contents.

## Configuration

- `DATA_MEM_CYCLE_COUNTER_EN`:
  - Defined: the 64-bit counter exists and is readable at 0x8/0xC.
  - Undefined: no counter register is built, and 0x8/0xC read 0 like unmapped offsets.

## Test plan

- RAM byte lanes:
  - Write 32'hAABBCCDD with `ram_w`=4'b1111 at 0x40.
  - Then write 32'h00001100 with `ram_w`=4'b0010.
  - Read 0x40 must return 32'hAABB11DD.
  - Read with `ram_r`=0 must return 0.
- Read-during-write: with word 0x80 holding 0x0, drive a same-cycle read and write of 0x12345678. `ram_in` must be 0 that cycle and 0x12345678 the next.
- FIFO fill/overflow, with `con_ready`=0:
  - Push 0x41,0x42,0x43,0x44: STATUS must read 0x1 (full).
  - A fifth push of 0x45 is dropped and STATUS must read 0x5.
  - Raise `con_ready`: the console must emit 0x41..0x44 in order, then `con_valid`=0 and STATUS=0x6.
- Simultaneous push/pop at full: with the FIFO full and `con_ready`=1, push 0x50. Count must stay 4, overflow must stay 0, and 0x50 must be the last byte drained.
- Cycle counter (macro defined):
  - CYCLE_LO read 10 cycles after reset release must be 10.
  - Force the counter to 32'hFFFF_FFFF low: the next cycle, CYCLE_HI increments and CYCLE_LO is 0.
  - With the macro undefined, both offsets read 0.
- Async reset: assert `rst_n`=0 mid-drain with 3 bytes queued. `con_valid` must fall without a clock edge, and after release STATUS must be 0x2.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the core: word RAM with byte-lane writes plus an
// MMIO window holding a buffered console transmit FIFO and a cycle counter.
// Optional feature macro: DATA_MEM_CYCLE_COUNTER_EN builds the 64-bit cycle
// counter at MMIO offsets 0x8/0xC; without it those offsets read 0.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_r,
  input  logic [3:0]  ram_w,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_out,
  output logic [31:0] ram_in,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        con_overflow
);

  localparam int unsigned WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [15:0] OFF_TXDATA   = 16'h0000;
  localparam logic [15:0] OFF_STATUS   = 16'h0004;
  localparam logic [15:0] OFF_CYCLE_LO = 16'h0008;
  localparam logic [15:0] OFF_CYCLE_HI = 16'h000C;

  logic [31:0]           mem [WORDS];
  logic [7:0]            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  overflow;

  logic                  is_mmio_c;
  logic [15:0]           offset_c;
  logic [ADDR_WIDTH-1:0] word_idx_c;
  logic                  empty_c;
  logic                  full_c;
  logic                  pop_c;
  logic                  push_req_c;
  logic                  push_ok_c;
  logic                  drop_c;
  logic                  clr_c;
  logic                  ram_we_c;
  logic [31:0]           rd_data_c;

  // Address decode and FIFO handshake qualifiers.
  assign is_mmio_c  = (ram_addr[31:16] == MMIO_BASE[31:16]);
  assign offset_c   = ram_addr[15:0];
  assign word_idx_c = ram_addr[ADDR_WIDTH+1:2];
  assign empty_c    = (count == '0);
  assign full_c     = (count == CNT_W'(FIFO_DEPTH));
  assign pop_c      = !empty_c && con_ready;
  assign push_req_c = is_mmio_c && (offset_c == OFF_TXDATA) && ram_w[0];
  assign push_ok_c  = push_req_c && (!full_c || pop_c);
  assign drop_c     = push_req_c && full_c && !pop_c;
  assign clr_c      = is_mmio_c && (offset_c == OFF_STATUS) && (ram_w != 4'b0000);
  assign ram_we_c   = rst_n && !is_mmio_c;

  assign con_valid    = !empty_c;
  assign con_data     = empty_c ? 8'h00 : fifo_mem[rd_ptr];
  assign con_overflow = overflow;

`ifdef DATA_MEM_CYCLE_COUNTER_EN
  logic [63:0] cycle_cnt;

  // Free-running cycle counter, wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 64'd1;
  end
`endif

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_w[i]) mem[word_idx_c][8*i +: 8] <= ram_out[8*i +: 8];
      end
    end
  end

  // FIFO payload storage; occupancy lives in the control registers below.
  always_ff @(posedge clk) begin
    if (push_ok_c) fifo_mem[wr_ptr] <= ram_out[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow (a drop beats a clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop_c)     overflow <= 1'b1;
      else if (clr_c) overflow <= 1'b0;
    end
  end

  // Zero-latency read mux over RAM and the MMIO registers.
  always_comb begin
    rd_data_c = '0;
    if (rst_n && ram_r) begin
      if (is_mmio_c) begin
        case (offset_c)
          OFF_STATUS:   rd_data_c = {29'b0, overflow, empty_c, full_c};
`ifdef DATA_MEM_CYCLE_COUNTER_EN
          OFF_CYCLE_LO: rd_data_c = cycle_cnt[31:0];
          OFF_CYCLE_HI: rd_data_c = cycle_cnt[63:32];
`endif
          default:      rd_data_c = '0;
        endcase
      end else begin
        rd_data_c = mem[word_idx_c];
      end
    end
  end

  assign ram_in = rd_data_c;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic, compared each cycle against a queue/array reference model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] MMIO  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_r = 1'b0;
  logic [3:0]  ram_w = 4'b0;
  logic [31:0] ram_addr = 32'b0;
  logic [31:0] ram_out = 32'b0;
  logic [31:0] ram_in;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready = 1'b0;
  logic        con_overflow;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [31:0] m_ram [1024];
  logic [3:0]  m_kn  [1024];
  bit          kn_init;
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic [63:0] m_cnt;
  logic [63:0] m_cnt_adj = 64'd0;
  bit          u_mmio;
  bit          u_full;
  bit          u_pop;
  bit          u_drop;
  int          u_idx;

  // Literal expectations posted by the stimulus for the next sample point
  bit          lit_en = 1'b0;
  int          lit_sel = 0;
  string       lit_name = "";
  logic [31:0] lit_exp = 32'b0;

  data_mem_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ram_r        (ram_r),
    .ram_w        (ram_w),
    .ram_addr     (ram_addr),
    .ram_out      (ram_out),
    .ram_in       (ram_in),
    .con_data     (con_data),
    .con_valid    (con_valid),
    .con_ready    (con_ready),
    .con_overflow (con_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected read data: bit 32 says whether the value is known.
  function automatic logic [32:0] exp_read();
    logic [15:0] off;
    logic [63:0] c;
    off = ram_addr[15:0];
    c   = m_cnt + m_cnt_adj;
    if (!ram_r) return {1'b1, 32'h0};
    if (ram_addr[31:16] == MMIO[31:16]) begin
      if (off == 16'h4)
        return {1'b1, 29'b0, m_ovf, (m_q.size() == 0), (m_q.size() == DEPTH)};
`ifdef DATA_MEM_CYCLE_COUNTER_EN
      if (off == 16'h8) return {1'b1, c[31:0]};
      if (off == 16'hC) return {1'b1, c[63:32]};
`endif
      return {1'b1, 32'h0};
    end
    return {(m_kn[ram_addr[11:2]] == 4'hF), m_ram[ram_addr[11:2]]};
  endfunction

  // Model: apply the spec's rules to the inputs seen at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!kn_init) begin
        foreach (m_kn[i]) m_kn[i] = 4'h0;
        kn_init = 1'b1;
      end
      m_q.delete();
      m_ovf = 1'b0;
      m_cnt = 64'd0;
    end else begin
      u_mmio = (ram_addr[31:16] == MMIO[31:16]);
      u_idx  = int'(ram_addr[11:2]);
      u_full = (m_q.size() == DEPTH);
      u_pop  = (m_q.size() != 0) && con_ready;
      u_drop = 1'b0;
      if (!u_mmio) begin
        for (int i = 0; i < 4; i++)
          if (ram_w[i]) m_ram[u_idx][8*i +: 8] = ram_out[8*i +: 8];
        m_kn[u_idx] = m_kn[u_idx] | ram_w;
      end
      if (u_pop) void'(m_q.pop_front());
      if (u_mmio && ram_addr[15:0] == 16'h0 && ram_w[0]) begin
        if (u_full && !u_pop) u_drop = 1'b1;
        else                  m_q.push_back(ram_out[7:0]);
      end
      if (u_drop) m_ovf = 1'b1;
      else if (u_mmio && ram_addr[15:0] == 16'h4 && ram_w != 4'h0) m_ovf = 1'b0;
      m_cnt = m_cnt + 64'd1;
    end
  end

  // Compare process: sampled 1 time unit after each falling clock edge, and
  // 1 time unit after reset assertion (no clock needed there).
  always begin
    logic [32:0] e;
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      chk("rst_ram_in", 64'(ram_in), 64'h0);
      chk("rst_con_valid", 64'(con_valid), 64'h0);
      chk("rst_con_data", 64'(con_data), 64'h0);
      chk("rst_con_overflow", 64'(con_overflow), 64'h0);
    end else begin
      e = exp_read();
      if (e[32]) chk("ram_in", 64'(ram_in), 64'(e[31:0]));
      chk("con_valid", 64'(con_valid), 64'(m_q.size() != 0));
      chk("con_data", 64'(con_data), 64'((m_q.size() != 0) ? m_q[0] : 8'h00));
      chk("con_overflow", 64'(con_overflow), 64'(m_ovf));
      if (lit_en) begin
        if (lit_sel == 0) chk(lit_name, 64'(ram_in), 64'(lit_exp));
        else              chk(lit_name, 64'({con_valid, con_data}), 64'({1'b1, lit_exp[7:0]}));
      end
    end
  end

  task automatic drive(input logic r, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    ram_r     = r;
    ram_w     = w;
    ram_addr  = a;
    ram_out   = d;
    con_ready = rdy;
  endtask

  task automatic lit(input string nm, input int sel, input logic [31:0] exp);
    lit_en   = 1'b1;
    lit_sel  = sel;
    lit_name = nm;
    lit_exp  = exp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  initial begin
    logic [31:0] up;
    int          sel;
    logic [9:0]  ridx;

    // Reset, then release
    repeat (3) step();
    rst_n = 1'b1;

`ifdef DATA_MEM_CYCLE_COUNTER_EN
    drive(0, 4'h0, 32'h0, 32'h0, 0);
    repeat (10) step();
    drive(1, 4'h0, MMIO | 32'h8, 32'h0, 0);
    lit("cycle_lo_after_10", 0, 32'd10);
    step();
`else
    drive(1, 4'h0, MMIO | 32'h8, 32'h0, 0);
    lit("cycle_lo_disabled", 0, 32'h0);
    step();
    drive(1, 4'h0, MMIO | 32'hC, 32'h0, 0);
    lit("cycle_hi_disabled", 0, 32'h0);
    step();
`endif

    // RAM byte lanes
    drive(0, 4'hF, 32'h40, 32'hAABBCCDD, 0); step();
    drive(0, 4'b0010, 32'h40, 32'h00001100, 0); step();
    drive(1, 4'h0, 32'h40, 32'h0, 0); lit("ram_lane_merge", 0, 32'hAABB11DD); step();
    drive(0, 4'h0, 32'h40, 32'h0, 0); lit("ram_read_strobe_low", 0, 32'h0); step();

    // Read-during-write returns the pre-edge value
    drive(0, 4'hF, 32'h80, 32'h0, 0); step();
    drive(1, 4'hF, 32'h80, 32'h12345678, 0); lit("rdw_old_value", 0, 32'h0); step();
    drive(1, 4'h0, 32'h80, 32'h0, 0); lit("rdw_new_value", 0, 32'h12345678); step();

    // FIFO fill, overflow and drain
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'h1, MMIO, 32'(8'h41 + i), 0); step();
    end
    drive(1, 4'h0, MMIO | 32'h4, 32'h0, 0); lit("status_full", 0, 32'h1); step();
    drive(0, 4'h1, MMIO, 32'h45, 0); step();
    drive(1, 4'h0, MMIO | 32'h4, 32'h0, 0); lit("status_full_ovf", 0, 32'h5); step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'h0, 32'h0, 32'h0, 1); lit("drain_order", 1, 32'(8'h41 + i)); step();
    end
    drive(1, 4'h0, MMIO | 32'h4, 32'h0, 1); lit("status_empty_ovf", 0, 32'h6); step();
    drive(0, 4'hF, MMIO | 32'h4, 32'h0, 0); step();
    drive(1, 4'h0, MMIO | 32'h4, 32'h0, 0); lit("status_ovf_cleared", 0, 32'h2); step();

    // Push and pop together while full
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'h1, MMIO, 32'(8'h60 + i), 0); step();
    end
    drive(0, 4'h1, MMIO, 32'h50, 1); step();
    drive(1, 4'h0, MMIO | 32'h4, 32'h0, 0); lit("status_full_no_ovf", 0, 32'h1); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'h0, 32'h0, 32'h0, 1); lit("simul_drain", 1, 32'(8'h61 + i)); step();
    end
    drive(0, 4'h0, 32'h0, 32'h0, 1); lit("simul_last_byte", 1, 32'h50); step();
    drive(0, 4'h0, 32'h0, 32'h0, 0); step();

`ifdef DATA_MEM_CYCLE_COUNTER_EN
    // Jump the counter to the low-word wrap point
    @(negedge clk);
    #2;
    force dut.cycle_cnt = 64'h0000_0005_FFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    m_cnt_adj = 64'h0000_0005_FFFF_FFFF - m_cnt;
    step();
    drive(1, 4'h0, MMIO | 32'h8, 32'h0, 0); lit("cycle_lo_wrapped", 0, 32'h0); step();
    drive(1, 4'h0, MMIO | 32'hC, 32'h0, 0); lit("cycle_hi_carry", 0, 32'h6); step();
`endif

    // Asynchronous reset mid-drain with 3 bytes queued
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'h1, MMIO, 32'(8'h70 + i), 0); step();
    end
    drive(0, 4'h0, 32'h0, 32'h0, 1); step();
    #1 rst_n = 1'b0;
    #3 drive(1, 4'h0, 32'h40, 32'h0, 1);
    step();
    step();
    rst_n = 1'b1;
    drive(1, 4'h0, MMIO | 32'h4, 32'h0, 0); lit("status_after_reset", 0, 32'h2); step();
    drive(1, 4'h0, 32'h40, 32'h0, 0); lit("ram_kept_over_reset", 0, 32'hAABB11DD); step();

    // Seed a small word pool for random traffic
    for (int i = 0; i < 16; i++) begin
      drive(0, 4'hF, 32'(i * 4), $urandom, 0); step();
    end

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      sel  = $urandom_range(0, 9);
      up   = $urandom;
      ridx = 10'($urandom_range(0, 15));
      if (up[31:16] == MMIO[31:16]) up[31] = 1'b0;
      case (sel)
        0, 1, 2: drive(1'($urandom), 4'($urandom), {up[31:12], ridx, 2'b00}, $urandom,
                       1'($urandom));
        3, 4:    drive(1'($urandom), 4'($urandom_range(0, 15) | ($urandom_range(0, 3) != 0)),
                       MMIO, $urandom, ($urandom_range(0, 2) == 0));
        5:       drive(1, 4'h0, MMIO | 32'h4, 32'h0, 1'($urandom));
        6:       drive(1'($urandom), 4'($urandom), MMIO | 32'h4, $urandom, 1'($urandom));
        7:       drive(1, 4'h0, MMIO | (($urandom_range(0, 1) != 0) ? 32'h8 : 32'hC), 32'h0,
                       1'($urandom));
        8:       drive(1'($urandom), 4'($urandom),
                       MMIO | (($urandom_range(0, 1) != 0) ? 32'h10 : 32'hFFFC), $urandom,
                       1'($urandom));
        default: drive(0, 4'h0, {up[31:12], ridx, 2'b00}, 32'h0, 1'($urandom));
      endcase
      step();
    end

    drive(0, 4'h0, 32'h0, 32'h0, 0);
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
